dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 32: number of 32-bit data words stored.
REQ-002 SHALL have parameter LATENCY, default 4: cycles from request acceptance to ack_o; legal range 1..15.
REQ-003 clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 req_i  input  1  request valid from the pipeline MEM stage.
REQ-006 we_i  input  1  1 = write, 0 = read; sampled with req_i.
REQ-007 addr_i  input  32  byte address; sampled with req_i.
REQ-008 data_i  input  32  write data; sampled with req_i.
REQ-009 ack_o  output  1  one-cycle completion pulse.
REQ-010 data_o  output  32  read data; valid only while ack_o=1.
REQ-011 busy_o  output  1  1 while a request is outstanding; the pipeline uses it to stall PC, IF/ID and ID/EX.
REQ-012 err_o  output  1  qualifies ack_o; 1 = request rejected.

Function
REQ-013 States SHALL be IDLE, BUSY and ACK.
REQ-014 In IDLE with req_i=1, the block SHALL capture we_i, addr_i and data_i into internal registers.
REQ-015 After capture, the FSM SHALL go to BUSY, or directly to ACK when LATENCY=1.
REQ-016 BUSY SHALL last exactly LATENCY-1 cycles, timed by a down-counter loaded with LATENCY-1 at capture.
REQ-017 Timing: a request accepted in cycle N SHALL see ack_o=1 in cycle N+LATENCY only, then return to IDLE in cycle N+LATENCY+1.
REQ-018 req_i SHALL be ignored in BUSY and ACK, so minimum request spacing is LATENCY+1 cycles.
REQ-019 busy_o SHALL be 1 in BUSY and ACK and 0 in IDLE; busy_o is registered.
REQ-020 Word index SHALL be addr[31:2].
REQ-021 A request SHALL be in error if addr[1:0]!=0 or the word index >= DEPTH.
REQ-022 An error request SHALL give ack_o=1 and err_o=1 with data_o=0, and SHALL NOT modify memory.
REQ-023 A good write SHALL update the addressed word on the ACK-cycle clock edge, with data_o=0 during its ack.
REQ-024 A good read SHALL drive the addressed word on data_o during ACK.
REQ-025 Read data SHALL reflect every write acked earlier.
REQ-026 err_o and data_o SHALL be 0 whenever ack_o=0.
REQ-027 Captured request fields SHALL NOT change between capture and ACK, whatever the inputs do.

Reset
REQ-028 With rst_i=1 at a clock edge: FSM to IDLE; counter, captured fields, ack_o, err_o, busy_o and data_o to 0.
REQ-029 Reset in BUSY or ACK SHALL abort the outstanding request; a pending write SHALL NOT be committed, and no ack_o is issued.
REQ-030 Reset SHALL NOT clear the memory array, so bench preload survives reset.
REQ-031 req_i in the cycle where rst_i=1 SHALL be ignored.

Structure
REQ-032 Shared package dmem_pkg SHALL hold the state enum type, default DEPTH and LATENCY, and the word-index width constant.
REQ-033 The storage array SHALL be one sub-module, dmem_array: one synchronous write port and an asynchronous read port indexed by the captured address.
REQ-034 The FSM, counter and error check SHALL live in dmem_responder.

Verification
REQ-035 Read after preload: preload word 3=0xDEADBEEF; read addr 0x0C at cycle 0 -> busy_o=1 cycles 1-4, ack_o=1, data_o=0xDEADBEEF, err_o=0 at cycle 4; IDLE at cycle 5.
REQ-036 Write then read: write 0x12345678 to 0x10, wait for ack, then read 0x10 -> read ack data_o=0x12345678; an intervening req_i pulse in BUSY is ignored (exactly two acks).
REQ-037 Errors: read 0x0E (misaligned) and write 0x80 with DEPTH=32 (out of range) -> each ack has err_o=1 and data_o=0; word 0 unchanged afterwards.
REQ-038 Reset mid-write: write 0xAAAA5555 to 0x04, rst_i=1 in 2nd BUSY cycle -> no ack_o, busy_o=0 next cycle, later read of 0x04 returns its preload value.
REQ-039 LATENCY=1: read in cycle N -> ack_o in cycle N+1; back-to-back requests accepted in N and N+2 only.
REQ-040 Input change: change addr_i and data_i every cycle during BUSY -> response matches the values captured at acceptance.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and defaults for the data-memory responder
package dmem_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
   localparam int DEF_DEPTH = 32;
   localparam int DEF_LATENCY = 4;
   localparam int IDX_W = 30;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with one synchronous write port and an asynchronous read port
module dmem_array import dmem_pkg::*; #(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);
   logic [31:0] mem [DEPTH];
   always_ff @(posedge clk_i)
      if (we_i) mem[waddr_i] <= wdata_i;
   assign rdata_o = 32'(raddr_i) < 32'(DEPTH) ? mem[raddr_i] : '0;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder with alignment/range checking
module dmem_responder import dmem_pkg::*; #(
   parameter int DEPTH = DEF_DEPTH,
   parameter int LATENCY = DEF_LATENCY
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic        ack_o,
   output logic [31:0] data_o,
   output logic        busy_o,
   output logic        err_o
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   state_t state;
   logic [3:0] cnt;
   logic cap_we, cap_err, req_err, commit;
   logic [AW-1:0] cap_idx;
   logic [31:0] cap_data, rdata;
   assign req_err = addr_i[1:0] != 2'b00 || 32'(addr_i[31:32-IDX_W]) >= 32'(DEPTH);
   // errored requests never reach the array, and reset aborts a pending write
   assign commit = state == ACK && cap_we && !cap_err && !rst_i;
   assign data_o = ack_o && !err_o && !cap_we ? rdata : '0;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         cnt <= '0;
         cap_we <= 1'b0;
         cap_err <= 1'b0;
         cap_idx <= '0;
         cap_data <= '0;
         ack_o <= 1'b0;
         err_o <= 1'b0;
         busy_o <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_i) begin
               cap_we <= we_i;
               cap_err <= req_err;
               cap_idx <= addr_i[AW+1:2];
               cap_data <= data_i;
               cnt <= 4'(LATENCY - 1);
               busy_o <= 1'b1;
               if (LATENCY == 1) begin
                  state <= ACK;
                  ack_o <= 1'b1;
                  err_o <= req_err;
               end else state <= BUSY;
            end
            BUSY: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= ACK;
                  ack_o <= 1'b1;
                  err_o <= cap_err;
               end
            end
            ACK: begin
               state <= IDLE;
               ack_o <= 1'b0;
               err_o <= 1'b0;
               busy_o <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
   dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
      .clk_i(clk_i),
      .we_i(commit),
      .waddr_i(cap_idx),
      .wdata_i(cap_data),
      .raddr_i(cap_idx),
      .rdata_o(rdata)
   );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks for dmem_responder at LATENCY 4 and 1
module tb_dmem_responder;
   logic clk = 1'b0, rst = 1'b1;
   logic req = 1'b0, we = 1'b0, ack, busy, err;
   logic [31:0] addr = '0, din = '0, dout;
   logic req1 = 1'b0, we1 = 1'b0, ack1, busy1, err1;
   logic [31:0] addr1 = '0, din1 = '0, dout1;
   int n_cmp = 0, n_bad = 0;
   logic [31:0] rd;
   logic re;
   int acks;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(32), .LATENCY(4)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .data_i(din),
      .ack_o(ack), .data_o(dout), .busy_o(busy), .err_o(err));

   dmem_responder #(.DEPTH(32), .LATENCY(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1), .addr_i(addr1), .data_i(din1),
      .ack_o(ack1), .data_o(dout1), .busy_o(busy1), .err_o(err1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input bit scr,
                      output logic [31:0] r_data, output logic r_err);
      int n;
      logic got;
      @(posedge clk); #1 req = 1'b1; we = w; addr = a; din = d;
      @(posedge clk); #1 req = 1'b0;
      got = 1'b0; n = 0; r_data = '1; r_err = 1'bx;
      while (!got && n < 20) begin
         @(negedge clk);
         if (ack) begin
            got = 1'b1; r_data = dout; r_err = err;
         end else begin
            n++;
            if (scr) begin addr = $urandom; din = $urandom; end
         end
      end
      chk("ack_seen", 32'(got), 32'd1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_data", dout, 0);
      chk("rst_busy1", 32'(busy1), 0);
      @(posedge clk); #1 rst = 1'b0;

      txn(1'b1, 32'h0C, 32'hDEADBEEF, 1'b0, rd, re);
      chk("wr3_err", 32'(re), 0);
      chk("wr3_data", rd, 0);
      txn(1'b1, 32'h04, 32'h11112222, 1'b0, rd, re);
      txn(1'b1, 32'h00, 32'hCAFEF00D, 1'b0, rd, re);

      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;

      // timed read: accepted at cycle 0, ack at cycle 4, idle at cycle 5
      @(posedge clk); #1 req = 1'b1; we = 1'b0; addr = 32'h0C;
      @(posedge clk); #1 req = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk($sformatf("t_busy_c%0d", k), 32'(busy), 32'(k <= 4));
         chk($sformatf("t_ack_c%0d", k), 32'(ack), 32'(k == 4));
         chk($sformatf("t_data_c%0d", k), dout, k == 4 ? 32'hDEADBEEF : 32'h0);
         chk($sformatf("t_err_c%0d", k), 32'(err), 0);
         if (k < 5) @(posedge clk);
      end

      @(posedge clk); #1 req = 1'b1; we = 1'b1; addr = 32'h10; din = 32'h12345678;
      @(posedge clk); #1 req = 1'b0;
      @(posedge clk); #1 req = 1'b1; we = 1'b1; addr = 32'h14; din = 32'hFFFFFFFF;
      @(posedge clk); #1 req = 1'b0;
      acks = 0;
      repeat (10) begin @(negedge clk); if (ack) acks++; end
      chk("busy_req_ignored", 32'(acks), 1);
      txn(1'b0, 32'h10, 32'h0, 1'b0, rd, re);
      chk("rd10_data", rd, 32'h12345678);
      chk("rd10_err", 32'(re), 0);

      txn(1'b0, 32'h0E, 32'h0, 1'b0, rd, re);
      chk("mis_err", 32'(re), 1);
      chk("mis_data", rd, 0);
      txn(1'b1, 32'h80, 32'hFFFFFFFF, 1'b0, rd, re);
      chk("oor_err", 32'(re), 1);
      chk("oor_data", rd, 0);
      txn(1'b0, 32'h00, 32'h0, 1'b0, rd, re);
      chk("w0_data", rd, 32'hCAFEF00D);
      chk("w0_err", 32'(re), 0);

      // reset in the second BUSY cycle, with a request offered alongside it
      @(posedge clk); #1 req = 1'b1; we = 1'b1; addr = 32'h04; din = 32'hAAAA5555;
      @(posedge clk); #1 req = 1'b0;
      @(posedge clk); #1 rst = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h0C;
      @(posedge clk); #1 rst = 1'b0; req = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_ack", 32'(ack), 0);
      acks = 0;
      repeat (6) begin @(negedge clk); if (ack || busy) acks++; end
      chk("abort_no_ack", 32'(acks), 0);
      txn(1'b0, 32'h04, 32'h0, 1'b0, rd, re);
      chk("rd04_data", rd, 32'h11112222);

      txn(1'b1, 32'h08, 32'h0BADCAFE, 1'b1, rd, re);
      chk("scr_wr_err", 32'(re), 0);
      txn(1'b0, 32'h08, 32'h0, 1'b0, rd, re);
      chk("scr_wr_data", rd, 32'h0BADCAFE);
      txn(1'b0, 32'h0C, 32'h0, 1'b1, rd, re);
      chk("scr_rd_data", rd, 32'hDEADBEEF);

      @(posedge clk); #1 req1 = 1'b1; we1 = 1'b1; addr1 = 32'h08; din1 = 32'h55AA55AA;
      @(posedge clk); #1 req1 = 1'b0;
      @(negedge clk);
      chk("l1_wr_ack", 32'(ack1), 1);
      chk("l1_wr_data", dout1, 0);
      repeat (2) @(posedge clk);
      #1 req1 = 1'b1; we1 = 1'b0; addr1 = 32'h08;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1 if (k == 4) req1 = 1'b0;
         @(negedge clk);
         chk($sformatf("l1_ack_c%0d", k), 32'(ack1), 32'(k % 2));
         chk($sformatf("l1_busy_c%0d", k), 32'(busy1), 32'(k % 2));
         chk($sformatf("l1_data_c%0d", k), dout1, k % 2 == 1 ? 32'h55AA55AA : 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
